chf_cart_loader: RTL
====================

// Module: chf_cart_loader
// PURPOSE
//  Sits between hps_io's ioctl download port and chf_core's cartridge memory.
//  Accepts ROMBIN bytes and writes them to cart RAM over a req/ack port,
//  throttling hps_io with ioctl_wait.
//  Holds the core in reset during a load and for a settle period afterwards.
//  Publishes the loaded size and the address mirror mask used by the cart decoder.
// PARAMETERS
//  ADDR_W     16       cart address width; max image 2^ADDR_W bytes
//  CART_INDEX 8'd1     ioctl_index value that selects a cartridge load
//  POST_HOLD  16       clk cycles core_reset stays high after download ends (>=2)
//  MIN_MASK   16'h07FF smallest mirror mask (2 KB cart granularity)
// PORTS
//  clk            in  1        system clock (clk_sys)
//  reset          in  1        asynchronous, active-high
//  ioctl_download in  1        download window from hps_io
//  ioctl_index    in  8        download target
//  ioctl_wr       in  1        1-cycle byte strobe
//  ioctl_addr     in  25       byte offset in file
//  ioctl_dout     in  8        byte data
//  ioctl_wait     out 1        stall hps_io while a write is outstanding
//  mem_req        out 1        cart RAM write request, held until mem_ack
//  mem_addr       out ADDR_W   write address, stable while mem_req
//  mem_din        out 8        write data, stable while mem_req
//  mem_ack        in  1        1-cycle accept; completes current request
//  cart_size      out ADDR_W+1 bytes loaded (highest accepted offset + 1)
//  cart_mask      out ADDR_W   mirror mask for cart address decode
//  cart_valid     out 1        cart image present and usable
//  core_reset     out 1        reset request to chf_core
// BEHAVIOUR
//  Reset values: all outputs 0 (ioctl_wait, mem_req, mem_addr, mem_din,
//   cart_size, cart_mask, cart_valid, core_reset); FSM -> IDLE.
//   Async reset mid-write drops mem_req at once; the partial image is abandoned.
//  FSM: IDLE, LOAD, WRITE, HOLD. Download edges use a registered copy of ioctl_download.
//  IDLE: on the rising edge of ioctl_download with ioctl_index==CART_INDEX, go to LOAD.
//   On entry: cart_size=0, cart_valid=0, core_reset=1.
//   Non-matching index: block stays idle, all outputs unchanged.
//  LOAD, ioctl_wr=1, ioctl_addr < 2^ADDR_W:
//   - latch mem_addr/mem_din, set mem_req=1 and ioctl_wait=1 on the next edge, go to WRITE
//   - cart_size <= max(cart_size, addr+1)
//  LOAD, ioctl_wr=1, ioctl_addr >= 2^ADDR_W: byte discarded, no request;
//   cart_size saturates at 2^ADDR_W.
//  WRITE: hold req/addr/din. On the mem_ack cycle, clear mem_req and ioctl_wait
//   on the next edge and return to LOAD.
//   ioctl_wr arriving in WRITE is a protocol violation; the byte is ignored.
//  Falling edge of ioctl_download:
//   - in LOAD: go to HOLD
//   - in WRITE: finish the outstanding write first, then go to HOLD
//  HOLD:
//   - entry cycle registers cart_mask = max(MIN_MASK, smear(cart_size-1)),
//     where smear ORs in every right-shift (next pow2 - 1); cart_size==0 gives MIN_MASK
//   - count POST_HOLD cycles, then core_reset=0, cart_valid=(cart_size!=0), go to IDLE
//   - a new matching download start during HOLD restarts LOAD
//  mem_ack outside WRITE is ignored. Latency: ioctl_wr to mem_req = 1 cycle.
//  ioctl_wait falls 1 cycle after mem_ack.
// TESTING
//  1. 4-byte load idx 1, data A5,5A,00,FF, ack 1 cycle after req -> writes at 0..3,
//     cart_size=4, cart_mask=07FF, core_reset falls 16 cycles after download end, cart_valid=1.
//  2. 3000-byte load -> cart_size=3000, cart_mask=0FFF; 2048-byte load -> mask 07FF.
//  3. mem_ack delayed 5 cycles, download dropped mid-write -> ioctl_wait high from
//     wr+1 until ack+1, addr/din stable; write completes before HOLD.
//  4. Download with ioctl_index=0 -> no mem_req, ioctl_wait=0, cart_* and core_reset unchanged.
//  5. Write at ioctl_addr=0x10000 (ADDR_W=16) -> no mem_req; cart_size=0x10000, cart_mask=FFFF.
//  6. reset pulse while in WRITE -> all outputs 0 immediately; next load behaves as in test 1.

Source files
------------

// File: rtl/chf_cart_loader.sv
`timescale 1ns/1ps
// chf_cart_loader
//   Bridges the hps_io ioctl download port to chf_core's cartridge RAM.
//   Each accepted ROM byte becomes one req/ack write to cart RAM, and
//   hps_io is stalled with ioctl_wait until that write is acknowledged.
//   The core is held in reset while a load is running and for POST_HOLD
//   cycles after it ends. Once the load has finished, the loaded size and
//   the mirror mask for the cart decoder are published.
//
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   ioctl_download    download window from hps_io
//   ioctl_index       download target; CART_INDEX selects a cart load
//   ioctl_wr          1-cycle byte strobe
//   ioctl_addr        byte offset in the file
//   ioctl_dout        byte data
//   ioctl_wait        stalls hps_io while a RAM write is outstanding
//   mem_req           cart RAM write request, held until mem_ack
//   mem_addr, mem_din write address/data, stable while mem_req is high
//   mem_ack           1-cycle accept that completes the current request
//   cart_size         bytes loaded (highest accepted offset + 1)
//   cart_mask         mirror mask for cart address decode
//   cart_valid        cart image present and usable
//   core_reset        reset request to chf_core
//
// Handshake: mem_req rises on the clock edge after ioctl_wr. While mem_req
// is high, mem_addr and mem_din stay constant. The request completes on the
// first cycle where mem_ack is high, and mem_req/ioctl_wait drop on the
// following edge. mem_ack has no effect while no request is outstanding.
module chf_cart_loader #(
    parameter int                ADDR_W     = 16,
    parameter logic [7:0]        CART_INDEX = 8'd1,
    parameter int                POST_HOLD  = 16,
    parameter logic [ADDR_W-1:0] MIN_MASK   = ADDR_W'(16'h07FF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    output logic [ADDR_W:0]   cart_size,
    output logic [ADDR_W-1:0] cart_mask,
    output logic              cart_valid,
    output logic              core_reset
);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, HOLD} state_t;

    localparam logic [ADDR_W:0]   SIZE_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] ONE_A     = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       HOLD_LAST = 16'(POST_HOLD - 1);

    state_t            state, state_nxt;
    logic              dl_q;
    logic              end_pend;     // download ended while a write was outstanding
    logic [15:0]       hold_cnt;
    logic              dl_rise, dl_fall, start;
    logic              in_range;
    logic [ADDR_W:0]   wr_size;
    logic [ADDR_W-1:0] smear;
    logic [ADDR_W-1:0] mask_calc;

    assign dl_rise  = ioctl_download & ~dl_q;
    assign dl_fall  = ~ioctl_download & dl_q;
    assign start    = dl_rise && (ioctl_index == CART_INDEX);
    assign in_range = (ioctl_addr >> ADDR_W) == 25'd0;
    assign wr_size  = {1'b0, ioctl_addr[ADDR_W-1:0]} + {1'b0, ONE_A};

    // Mirror mask: the next power of two at or above cart_size, minus one,
    // and never below MIN_MASK. When cart_size is 2^ADDR_W, the low bits are
    // zero, so the subtraction wraps to all ones. That is the correct mask.
    always_comb begin
        smear = cart_size[ADDR_W-1:0] - ONE_A;
        for (int i = 0; i < ADDR_W; i++) begin
            smear = smear | (smear >> 1);
        end
        if (cart_size == '0) begin
            mask_calc = MIN_MASK;
        end else begin
            mask_calc = (smear > MIN_MASK) ? smear : MIN_MASK;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD: begin
                if (dl_fall) begin
                    state_nxt = HOLD;
                end else if (ioctl_wr && in_range) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: if (mem_ack) state_nxt = (end_pend || dl_fall) ? HOLD : LOAD;
            HOLD: begin
                if (start) begin
                    state_nxt = LOAD;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: a write is outstanding exactly while in WRITE
    always_comb begin
        mem_req    = (state == WRITE);
        ioctl_wait = (state == WRITE);
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_q       <= 1'b0;
            end_pend   <= 1'b0;
            hold_cnt   <= '0;
            mem_addr   <= '0;
            mem_din    <= '0;
            cart_size  <= '0;
            cart_mask  <= '0;
            cart_valid <= 1'b0;
            core_reset <= 1'b0;
        end else begin
            dl_q <= ioctl_download;

            if (state_nxt == LOAD && (state == IDLE || state == HOLD)) begin
                cart_size  <= '0;
                cart_valid <= 1'b0;
                core_reset <= 1'b1;
                end_pend   <= 1'b0;
            end

            if (state == LOAD && !dl_fall && ioctl_wr) begin
                if (in_range) begin
                    mem_addr <= ioctl_addr[ADDR_W-1:0];
                    mem_din  <= ioctl_dout;
                    if (wr_size > cart_size) cart_size <= wr_size;
                end else begin
                    cart_size <= SIZE_FULL;
                end
            end

            if (state == WRITE && dl_fall) end_pend <= 1'b1;

            if (state != HOLD && state_nxt == HOLD) begin
                hold_cnt  <= '0;
                cart_mask <= mask_calc;
                end_pend  <= 1'b0;
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt + 16'd1;
                if (state_nxt == IDLE) begin
                    core_reset <= 1'b0;
                    cart_valid <= (cart_size != '0);
                end
            end
        end
    end

endmodule
